// File: rtl/ipgu_pkg.sv
// ipgu_pkg -- shared types and helpers for the image-pyramid controller.
//   ipgu_pyr_state_t : controller FSM state encoding
//   num_windows_f    : windows per axis at a given pyramid level,
//                      max(top - step*level, 1), returned as 4 bits
package ipgu_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SRC_READ = 2'd1,
      DRAIN    = 2'd2,
      WAIT_HEU = 2'd3
   } ipgu_pyr_state_t;

   function automatic logic [3:0] num_windows_f(input logic [2:0] lvl,
                                                input int         top,
                                                input int         step);
      int v;
      v = top - step * int'(lvl);
      // The coarsest levels never shrink below a single window.
      if (v < 1) begin
         return 4'd1;
      end else begin
         return v[3:0];
      end
   endfunction

endpackage

// File: rtl/ipgu_bank_seq.sv
// ipgu_bank_seq -- ping-pong bank select / write-enable pipeline.
// The source bank is read in the cycle its cs is raised; the pixel is
// written into the other bank one cycle later.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear of the delay stage (frame abort)
//   src_cs    : read strobe for the current source bank
//   src_sel   : 0 -> RAM1 is source, 1 -> RAM2 is source
//   cs_ram1/2 : bank chip selects (read or write)
//   we_ram1/2 : bank write enables
module ipgu_bank_seq (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic src_cs,
   input  logic src_sel,
   output logic cs_ram1,
   output logic cs_ram2,
   output logic we_ram1,
   output logic we_ram2
);

   logic src1;
   logic src2;
   logic dly1;
   logic dly2;

   assign src1 = src_cs & ~src_sel;
   assign src2 = src_cs &  src_sel;

   // One-cycle delay of each bank's read strobe; becomes the other bank's write.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         dly1 <= 1'b0;
         dly2 <= 1'b0;
      end else begin
         dly1 <= src1;
         dly2 <= src2;
      end
   end

   assign cs_ram1 = src1 | dly2;
   assign cs_ram2 = src2 | dly1;
   // A bank that is currently being read as source must never be written.
   assign we_ram1 = dly2 & ~src1;
   assign we_ram2 = dly1 & ~src2;

endmodule

// File: rtl/ipgu_pyramid_ctrl.sv
// ipgu_pyramid_ctrl -- walks one frame through NUM_LEVELS pyramid levels,
// reading each window from the source bank, writing it to the other bank,
// and handing each finished window to the HEU.
// Optional build macro: IPGU_PYRAMID_PERF_EN enables the stall_cycles counter.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, abort             : begin a frame (IDLE only) / cancel from any state
//   heu_rdy                  : HEU accepts the staged window
//   addr_x, addr_y           : current read coordinate from the address generator
//   x_begin..y_end           : current window bounds (end is inclusive)
//   ipgu_vld, ipgu_rdy       : window offered to HEU / idle and accepting start
//   cs_ram1/2, we_ram1/2     : ping-pong bank selects and write enables
//   inc_x                    : advance the address generator
//   window_done              : final pixel of the window is read next
//   level, num_windows       : current level and windows per axis
//   level_done, frame_done   : single-cycle completion pulses
//   stall_cycles             : HEU back-pressure cycle count
module ipgu_pyramid_ctrl
   import ipgu_pkg::*;
#(
   parameter int ADDR_W      = 18,
   parameter int NUM_LEVELS  = 6,
   parameter int WIN         = 20,
   parameter int TOP_WINDOWS = 15,
   parameter int STEP        = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  heu_rdy,
   input  logic [ADDR_W/2-1:0]   addr_x,
   input  logic [ADDR_W/2-1:0]   addr_y,
   input  logic [ADDR_W/2-1:0]   x_begin,
   input  logic [ADDR_W/2-1:0]   x_end,
   input  logic [ADDR_W/2-1:0]   y_begin,
   input  logic [ADDR_W/2-1:0]   y_end,
   output logic                  ipgu_vld,
   output logic                  ipgu_rdy,
   output logic                  cs_ram1,
   output logic                  cs_ram2,
   output logic                  we_ram1,
   output logic                  we_ram2,
   output logic                  inc_x,
   output logic                  window_done,
   output logic [2:0]            level,
   output logic [3:0]            num_windows,
   output logic                  level_done,
   output logic                  frame_done,
   output logic [15:0]           stall_cycles
);

   localparam int              AW         = ADDR_W / 2;
   localparam int              CW         = AW + 4;
   localparam logic [CW-1:0]   WIN_C      = CW'(WIN);
   localparam logic [2:0]      LAST_LEVEL = 3'(NUM_LEVELS - 1);

   ipgu_pyr_state_t state;
   logic            src_cs;
   logic            last_win;
   logic            at_end;
   logic            last_geom;
   logic [AW-1:0]   addr_x_inc;
   logic [CW-1:0]   span;
   logic [CW-1:0]   x_reach;
   logic [CW-1:0]   y_reach;

   // Wraps modulo 2^AW, so x_end==0 with addr_x all-ones still flags the final pixel.
   assign addr_x_inc  = addr_x + {{(AW-1){1'b0}}, 1'b1};
   assign window_done = (addr_y == y_end) && (addr_x_inc == x_end);
   assign at_end      = (addr_x == x_end) && (addr_y == y_end);

   // Last window of the level: its far edge lands on the level's pixel extent.
   // Widened by 4 bits so begin+WIN cannot wrap.
   assign span      = {{AW{1'b0}}, num_windows} * WIN_C;
   assign x_reach   = {4'b0000, x_begin} + WIN_C;
   assign y_reach   = {4'b0000, y_begin} + WIN_C;
   assign last_geom = window_done && (x_reach == span) && (y_reach == span);

   // Controller FSM with all its registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         level       <= 3'd0;
         num_windows <= 4'd0;
         last_win    <= 1'b0;
         src_cs      <= 1'b0;
         inc_x       <= 1'b0;
         ipgu_vld    <= 1'b0;
         ipgu_rdy    <= 1'b0;
         level_done  <= 1'b0;
         frame_done  <= 1'b0;
      end else if (abort) begin
         state       <= IDLE;
         level       <= 3'd0;
         num_windows <= num_windows_f(3'd0, TOP_WINDOWS, STEP);
         last_win    <= 1'b0;
         src_cs      <= 1'b0;
         inc_x       <= 1'b0;
         ipgu_vld    <= 1'b0;
         ipgu_rdy    <= 1'b1;
         level_done  <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         level_done <= 1'b0;
         frame_done <= 1'b0;
         if (last_geom) begin
            last_win <= 1'b1;
         end else begin
            last_win <= last_win;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= SRC_READ;
                  level       <= 3'd0;
                  num_windows <= num_windows_f(3'd0, TOP_WINDOWS, STEP);
                  src_cs      <= 1'b1;
                  inc_x       <= 1'b1;
                  ipgu_rdy    <= 1'b0;
               end else begin
                  ipgu_rdy    <= 1'b1;
               end
            end
            SRC_READ: begin
               if (at_end) begin
                  state  <= DRAIN;
                  src_cs <= 1'b0;
                  inc_x  <= 1'b0;
               end else begin
                  src_cs <= 1'b1;
                  inc_x  <= 1'b1;
               end
            end
            DRAIN: begin
               // Lets the delayed write of the final pixel land before handoff.
               state    <= WAIT_HEU;
               ipgu_vld <= 1'b1;
            end
            WAIT_HEU: begin
               if (heu_rdy) begin
                  ipgu_vld <= 1'b0;
                  if (!last_win) begin
                     state  <= SRC_READ;
                     src_cs <= 1'b1;
                     inc_x  <= 1'b1;
                  end else begin
                     last_win   <= 1'b0;
                     level_done <= 1'b1;
                     if (level == LAST_LEVEL) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                        ipgu_rdy   <= 1'b1;
                     end else begin
                        // New level swaps banks; hold off one cycle before reading.
                        level       <= level + 3'd1;
                        num_windows <= num_windows_f(level + 3'd1, TOP_WINDOWS, STEP);
                        state       <= SRC_READ;
                     end
                  end
               end else begin
                  ipgu_vld <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               src_cs   <= 1'b0;
               inc_x    <= 1'b0;
               ipgu_vld <= 1'b0;
               ipgu_rdy <= 1'b1;
            end
         endcase
      end
   end

   ipgu_bank_seq u_bank_seq (
      .clk     (clk),
      .rst     (rst),
      .clr     (abort),
      .src_cs  (src_cs),
      .src_sel (level[0]),
      .cs_ram1 (cs_ram1),
      .cs_ram2 (cs_ram2),
      .we_ram1 (we_ram1),
      .we_ram2 (we_ram2)
   );

`ifdef IPGU_PYRAMID_PERF_EN
   logic start_ok;

   assign start_ok = (state == IDLE) && start && !abort;

   // Saturating count of cycles the HEU holds a staged window back.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= 16'h0000;
      end else if (start_ok) begin
         stall_cycles <= 16'h0000;
      end else if (!abort && (state == WAIT_HEU) && !heu_rdy && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'h0001;
      end else begin
         stall_cycles <= stall_cycles;
      end
   end
`else
   assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_ipgu_pyramid_ctrl.sv
// tb_ipgu_pyramid_ctrl -- directed self-checking bench for ipgu_pyramid_ctrl.
// The bench plays the address generator: it advances the coordinate on inc_x
// and loads the next window bounds on every HEU handshake.
module tb_ipgu_pyramid_ctrl;

   localparam int AW = 9;
`ifdef IPGU_PYRAMID_PERF_EN
   localparam int EXP_STALL = 37;
`else
   localparam int EXP_STALL = 0;
`endif

   logic          clk = 1'b0;
   logic          rst, start, abort, heu_rdy;
   logic [AW-1:0] addr_x, addr_y, x_begin, x_end, y_begin, y_end;
   logic          ipgu_vld, ipgu_rdy, cs_ram1, cs_ram2, we_ram1, we_ram2;
   logic          inc_x, window_done, level_done, frame_done;
   logic [2:0]    level;
   logic [3:0]    num_windows;
   logic [15:0]   stall_cycles;

   int n_total = 0;
   int n_bad   = 0;

   int exp_nw [6] = '{15, 12, 9, 6, 3, 1};
   int rec_lvl [6];
   int rec_nw  [6];
   int b_level, b_idx;
   int cyc, n_cs1, n_cs2, n_we1, n_we2, n_ld, n_fd, first_cs1, first_we2;

   always #5 clk = ~clk;

   ipgu_pyramid_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .heu_rdy(heu_rdy),
      .addr_x(addr_x), .addr_y(addr_y), .x_begin(x_begin), .x_end(x_end),
      .y_begin(y_begin), .y_end(y_end), .ipgu_vld(ipgu_vld), .ipgu_rdy(ipgu_rdy),
      .cs_ram1(cs_ram1), .cs_ram2(cs_ram2), .we_ram1(we_ram1), .we_ram2(we_ram2),
      .inc_x(inc_x), .window_done(window_done), .level(level), .num_windows(num_windows),
      .level_done(level_done), .frame_done(frame_done), .stall_cycles(stall_cycles)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit win_last();
      return !(b_level == 0 && b_idx == 0);
   endfunction

   // Level 0 gets a leading non-last window at the origin; every other
   // window handed out is the last one of its level.
   task automatic load_window();
      int base;
      base    = win_last() ? (exp_nw[b_level] - 1) * 20 : 0;
      x_begin = AW'(base);
      x_end   = AW'(base + 19);
      y_begin = AW'(base);
      y_end   = AW'(base + 19);
      addr_x  = AW'(base);
      addr_y  = AW'(base);
   endtask

   task automatic prepare_frame();
      b_level = 0;
      b_idx   = 0;
      load_window();
   endtask

   task automatic clr_mon();
      n_cs1 = 0; n_cs2 = 0; n_we1 = 0; n_we2 = 0; n_ld = 0; n_fd = 0;
      first_cs1 = -1; first_we2 = -1;
      for (int i = 0; i < 6; i++) begin
         rec_lvl[i] = -1;
         rec_nw[i]  = -1;
      end
   endtask

   // One clock: called and returns 1 ns after a rising edge.
   task automatic tick();
      logic adv, hs;
      adv = (inc_x === 1'b1);
      hs  = (ipgu_vld === 1'b1) && (heu_rdy === 1'b1);
      if (hs && win_last()) begin
         rec_lvl[b_level] = int'(level);
         rec_nw[b_level]  = int'(num_windows);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (hs) begin
         if (win_last()) begin
            if (b_level < 5) begin
               b_level++;
               b_idx = 0;
               load_window();
            end
         end else begin
            b_idx++;
            load_window();
         end
      end else if (adv) begin
         if (addr_x == x_end) begin
            addr_x = x_begin;
            addr_y = (addr_y == y_end) ? y_begin : addr_y + AW'(1);
         end else begin
            addr_x = addr_x + AW'(1);
         end
      end
      if (cs_ram1 === 1'b1) begin
         n_cs1++;
         if (first_cs1 < 0) first_cs1 = cyc;
      end
      if (cs_ram2 === 1'b1) n_cs2++;
      if (we_ram1 === 1'b1) n_we1++;
      if (we_ram2 === 1'b1) begin
         n_we2++;
         if (first_we2 < 0) first_we2 = cyc;
      end
      if (level_done === 1'b1) n_ld++;
      if (frame_done === 1'b1) n_fd++;
   endtask

   initial begin
      bit w0_seen;
      int n_hold;
      cyc = 0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; heu_rdy = 1'b0;
      prepare_frame();
      clr_mon();

      // Reset state
      tick(); tick(); tick();
      chk("rst_rdy", int'(ipgu_rdy), 0);
      chk("rst_vld", int'(ipgu_vld), 0);
      chk("rst_inc", int'(inc_x), 0);
      chk("rst_cswe", int'({cs_ram1, cs_ram2, we_ram1, we_ram2}), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_nwin", int'(num_windows), 0);
      chk("rst_stall", int'(stall_cycles), 0);
      rst = 1'b0;
      tick();
      chk("rdy_after_rst", int'(ipgu_rdy), 1);

      // window_done including the modulo-2^AW wrap
      y_end = 9'd19; addr_y = 9'd19; x_end = 9'd0; addr_x = 9'd511; #1;
      chk("wd_wrap", int'(window_done), 1);
      addr_x = 9'd510; #1;
      chk("wd_nowrap", int'(window_done), 0);
      x_end = 9'd19; addr_x = 9'd18; #1;
      chk("wd_normal", int'(window_done), 1);
      addr_y = 9'd18; #1;
      chk("wd_wrong_row", int'(window_done), 0);
      prepare_frame();

      // start together with abort stays idle
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("sa_rdy", int'(ipgu_rdy), 1);
      chk("sa_inc", int'(inc_x), 0);
      tick();
      chk("sa_cs", int'(cs_ram1), 0);

      // Full frame, HEU always ready
      heu_rdy = 1'b1;
      prepare_frame();
      clr_mon();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_inc", int'(inc_x), 1);
      chk("start_cs1", int'(cs_ram1), 1);
      chk("start_rdy", int'(ipgu_rdy), 0);
      w0_seen = 1'b0;
      for (int i = 0; i < 6000 && n_fd == 0; i++) begin
         tick();
         if (ipgu_vld && !w0_seen) begin
            w0_seen = 1'b1;
            chk("w0_cs1", n_cs1, 400);
            chk("w0_we2", n_we2, 400);
            chk("w0_we1", n_we1, 0);
            chk("w0_lag", first_we2 - first_cs1, 1);
         end
      end
      chk("frame_done_cnt", n_fd, 1);
      chk("level_done_cnt", n_ld, 6);
      chk("frame_rdy", int'(ipgu_rdy), 1);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("lvl_%0d", i), rec_lvl[i], i);
         chk($sformatf("nwin_%0d", i), rec_nw[i], exp_nw[i]);
      end
      chk("tot_cs1", n_cs1, 2800);
      chk("tot_we1", n_we1, 1200);
      chk("tot_we2", n_we2, 1600);
      tick();
      chk("frame_idle_inc", int'(inc_x), 0);

      // HEU back-pressure in WAIT_HEU, with a stray start that must be ignored
      heu_rdy = 1'b0;
      prepare_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 1000 && !ipgu_vld; i++) tick();
      chk("stall_reach_vld", int'(ipgu_vld), 1);
      n_hold = 0;
      for (int i = 0; i < 37; i++) begin
         start = (i == 10);
         tick();
         if (ipgu_vld) n_hold++;
      end
      start = 1'b0;
      chk("vld_hold", n_hold, 37);
      chk("stall_cnt", int'(stall_cycles), EXP_STALL);
      heu_rdy = 1'b1;
      tick();
      chk("release_vld", int'(ipgu_vld), 0);
      chk("release_inc", int'(inc_x), 1);
      chk("release_cs1", int'(cs_ram1), 1);

      // Abort in the middle of a level-2 read
      for (int i = 0; i < 3000 && level != 3'd2; i++) tick();
      chk("reach_l2", int'(level), 2);
      for (int i = 0; i < 50; i++) tick();
      chk("l2_reading", int'(cs_ram1), 1);
      n_fd = 0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_cswe", int'({cs_ram1, cs_ram2, we_ram1, we_ram2}), 0);
      chk("abort_rdy", int'(ipgu_rdy), 1);
      chk("abort_inc", int'(inc_x), 0);
      chk("abort_level", int'(level), 0);
      chk("abort_nwin", int'(num_windows), 15);
      for (int i = 0; i < 5; i++) tick();
      chk("abort_no_fd", n_fd, 0);
      chk("abort_idle_rdy", int'(ipgu_rdy), 1);
      chk("abort_idle_cs", int'({cs_ram1, cs_ram2}), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
